// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory request arbiter.
// Imported by the ordering FIFO and the arbiter top.
package mem_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_fifo.sv
// Synchronous FIFO, DEPTH x W, with occupancy count.
// Holds the channel index of each outstanding request.
module mem_arb_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 1,
    localparam int AW   = clog2_min1(DEPTH),
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    dout,
    output logic [CNTW-1:0] cnt,
    output logic            full,
    output logic            empty
);

    logic [W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CNTW-1:0] r_cnt;
    logic            w_push;
    logic            w_pop;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == CNTW'(DEPTH));
    assign cnt    = r_cnt;
    assign dout   = r_mem[r_rptr];
    assign w_pop  = pop & ~empty;
    // A full FIFO may still take a push when it pops in the same cycle.
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= f_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNTW'(1);
                2'b01:   r_cnt <= r_cnt - CNTW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges NUM_CH req/addr_ok/data_ok masters onto one memory port.
// Responses are routed back in issue order via the ordering FIFO.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = ARB_RR,
    localparam int SW      = XLEN / 8,
    localparam int CW      = clog2_min1(NUM_CH),
    localparam int CNTW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [NUM_CH-1:0]    m_req,
    input  logic [NUM_CH-1:0]    m_write,
    input  logic [NUM_CH*SW-1:0] m_wstrb,
    input  logic [NUM_CH*XLEN-1:0] m_addr,
    input  logic [NUM_CH*XLEN-1:0] m_wdata,
    output logic [NUM_CH-1:0]    m_addr_ok,
    output logic [NUM_CH-1:0]    m_data_ok,
    output logic [XLEN-1:0]      m_rdata,
    output logic                 s_req,
    output logic                 s_write,
    output logic [SW-1:0]        s_wstrb,
    output logic [XLEN-1:0]      s_addr,
    output logic [XLEN-1:0]      s_wdata,
    input  logic                 s_addr_ok,
    input  logic                 s_data_ok,
    input  logic [XLEN-1:0]      s_rdata,
    output logic                 busy,
    output logic                 err_resp
);

    logic [NUM_CH-1:0] w_cand;
    logic [NUM_CH-1:0] w_gnt;
    logic [CW-1:0]     w_win;
    logic [CW-1:0]     w_head;
    logic [CNTW-1:0]   w_cnt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              r_err;

    // Full uses registered occupancy only, so s_data_ok never reaches s_req.
    assign w_cand = m_req & {NUM_CH{~w_full}};

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            logic [CW-1:0] r_ptr;
            logic [CW-1:0] w_sel;
            logic          w_hit;

            always_comb begin
                w_gnt = '0;
                w_win = '0;
                w_sel = '0;
                w_hit = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    w_sel = CW'((int'(r_ptr) + k) % NUM_CH);
                    if (!w_hit && w_cand[w_sel]) begin
                        w_hit        = 1'b1;
                        w_gnt[w_sel] = 1'b1;
                        w_win        = w_sel;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    r_ptr <= '0;
                end else if (w_push) begin
                    r_ptr <= (int'(w_win) == NUM_CH - 1) ?
                             '0 : w_win + CW'(1);
                end
            end
        end else begin : g_fixed
            always_comb begin
                w_gnt = '0;
                w_win = '0;
                for (int k = NUM_CH - 1; k >= 0; k--) begin
                    if (w_cand[k]) begin
                        w_gnt    = '0;
                        w_gnt[k] = 1'b1;
                        w_win    = CW'(k);
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        s_write = 1'b0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt[i]) begin
                s_write = m_write[i];
                s_wstrb = m_wstrb[i*SW +: SW];
                s_addr  = m_addr[i*XLEN +: XLEN];
                s_wdata = m_wdata[i*XLEN +: XLEN];
            end
        end
    end

    assign s_req     = |w_gnt;
    assign m_addr_ok = w_gnt & {NUM_CH{s_addr_ok}};
    assign w_push    = s_req & s_addr_ok;
    assign w_pop     = s_data_ok & ~w_empty;

    always_comb begin
        m_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_data_ok[i] = w_pop && (w_head == CW'(i));
        end
    end

    mem_arb_fifo #(
        .DEPTH (DEPTH),
        .W     (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_win),
        .dout  (w_head),
        .cnt   (w_cnt),
        .full  (w_full),
        .empty (w_empty)
    );

    // A response with nothing outstanding cannot be routed; remember it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_err <= 1'b0;
        end else if (s_data_ok && w_empty) begin
            r_err <= 1'b1;
        end
    end

    assign m_rdata  = s_rdata;
    assign busy     = (w_cnt != '0);
    assign err_resp = r_err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: RR instance plus a fixed-priority one.
// Stimulus queues expected grants/responses; a negedge monitor checks them.
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    logic [1:0]  m_req, m_write, m_addr_ok, m_data_ok;
    logic [7:0]  m_wstrb;
    logic [63:0] m_addr, m_wdata;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_req, s_write, s_addr_ok, s_data_ok, busy, err_resp;

    logic [1:0]  f_m_req, f_m_write, f_m_addr_ok, f_m_data_ok;
    logic [7:0]  f_m_wstrb;
    logic [63:0] f_m_addr, f_m_wdata;
    logic [31:0] f_m_rdata, f_s_addr, f_s_wdata, f_s_rdata;
    logic [3:0]  f_s_wstrb;
    logic        f_s_req, f_s_write, f_s_addr_ok, f_s_data_ok;
    logic        f_busy, f_err_resp;

    mem_req_arbiter #(.NUM_CH(2), .XLEN(32), .DEPTH(4), .ARB_MODE(1)) dut (
        .clk(clk), .rst_b(rst_b),
        .m_req(m_req), .m_write(m_write), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .busy(busy), .err_resp(err_resp)
    );

    mem_req_arbiter #(.NUM_CH(2), .XLEN(32), .DEPTH(4), .ARB_MODE(0)) dut_fx (
        .clk(clk), .rst_b(rst_b),
        .m_req(f_m_req), .m_write(f_m_write), .m_wstrb(f_m_wstrb),
        .m_addr(f_m_addr), .m_wdata(f_m_wdata),
        .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok), .m_rdata(f_m_rdata),
        .s_req(f_s_req), .s_write(f_s_write), .s_wstrb(f_s_wstrb),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_addr_ok(f_s_addr_ok), .s_data_ok(f_s_data_ok), .s_rdata(f_s_rdata),
        .busy(f_busy), .err_resp(f_err_resp)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wd;
    } gexp_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ga, ge;
    rexp_t ra, re;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic wr, input logic [3:0] st,
                          input logic [31:0] ad, input logic [31:0] wd);
        m_write[ch]         = wr;
        m_wstrb[ch*4 +: 4]  = st;
        m_addr[ch*32 +: 32] = ad;
        m_wdata[ch*32 +: 32] = wd;
    endtask

    task automatic exp_g(input logic [1:0] g, input logic wr, input logic [3:0] st,
                         input logic [31:0] ad, input logic [31:0] wd);
        gq.push_back('{g, wr, st, ad, wd});
    endtask

    task automatic exp_r(input logic [1:0] ch, input logic [31:0] d);
        rq.push_back('{ch, d});
    endtask

    // Monitor: pops an expectation whenever the RR instance presents a grant or response.
    always @(negedge clk) begin
        if (rst_b) begin
            if (m_addr_ok != 2'b00) begin
                ga = '{m_addr_ok, s_write, s_wstrb, s_addr, s_wdata};
                tests++;
                if (gq.size() == 0) begin
                    fails++;
                    $display("FAIL gnt_unexpected: got %h expected none", ga);
                end else begin
                    ge = gq.pop_front();
                    if (ga !== ge) begin
                        fails++;
                        $display("FAIL gnt: got %h expected %h at %0t", ga, ge, $time);
                    end
                end
            end
            if (m_data_ok != 2'b00) begin
                ra = '{m_data_ok, m_rdata};
                tests++;
                if (rq.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: got %h expected none", ra);
                end else begin
                    re = rq.pop_front();
                    if (ra !== re) begin
                        fails++;
                        $display("FAIL rsp: got %h expected %h at %0t", ra, re, $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0;
        m_req = '0; m_write = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        f_m_req = '0; f_m_write = '0; f_m_wstrb = '0;
        f_m_addr = {32'h2000, 32'h1000}; f_m_wdata = '0;
        f_s_addr_ok = 1'b0; f_s_data_ok = 1'b0; f_s_rdata = 32'h77;
        repeat (2) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_err", err_resp, 0);
        chk("rst_addr_ok", m_addr_ok, 0);
        chk("rst_data_ok", m_data_ok, 0);
        chk("rst_s_req", s_req, 0);
        rst_b = 1'b1;

        // Fixed priority: ch0 always wins, ch1 starves
        f_m_req = 2'b11; f_s_addr_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fx_gnt", f_m_addr_ok, 2'b01);
            chk("fx_addr", f_s_addr, 32'h1000);
            chk("fx_dok", f_m_data_ok, (k == 0) ? 2'b00 : 2'b01);
            cyc();
            f_s_data_ok = 1'b1;
        end
        f_m_req = '0; f_s_data_ok = 1'b0;
        #1;
        chk("fx_err", f_err_resp, 0);

        // Round robin 0,1,0,1 then full
        set_ch(0, 1'b0, 4'h0, 32'h40, 32'h0);
        set_ch(1, 1'b1, 4'hF, 32'h80, 32'hDEADBEEF);
        m_req = 2'b11; s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_g(2'b01, 1'b0, 4'h0, 32'h40, 32'h0);
            else            exp_g(2'b10, 1'b1, 4'hF, 32'h80, 32'hDEADBEEF);
            cyc();
        end
        chk("rr_full_sreq", s_req, 0);
        chk("rr_full_busy", busy, 1);
        m_req = '0; s_data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_rdata = 32'h10 + k;
            exp_r((k % 2 == 0) ? 2'b01 : 2'b10, 32'h10 + k);
            cyc();
        end
        s_data_ok = 1'b0;
        #1;
        chk("rr_drain_busy", busy, 0);
        m_req = 2'b11; s_addr_ok = 1'b0;
        #1;
        chk("rr_ptr_sreq", s_req, 1);
        chk("rr_ptr_addr", s_addr, 32'h40);
        chk("rr_ptr_aok", m_addr_ok, 0);
        cyc();

        // Depth limit, pop-while-full, push+pop
        m_req = 2'b01; s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g(2'b01, 1'b0, 4'h0, 32'h40, 32'h0);
            cyc();
        end
        chk("full_sreq", s_req, 0);
        chk("full_aok", m_addr_ok, 0);
        chk("full_busy", busy, 1);
        cyc();
        s_data_ok = 1'b1; s_rdata = 32'h20; exp_r(2'b01, 32'h20);
        #1;
        chk("full_pop_sreq", s_req, 0);
        cyc();
        s_data_ok = 1'b0;
        exp_g(2'b01, 1'b0, 4'h0, 32'h40, 32'h0);
        #1;
        chk("after_pop_sreq", s_req, 1);
        cyc();
        chk("refull_sreq", s_req, 0);
        m_req = '0; s_data_ok = 1'b1; s_rdata = 32'h21; exp_r(2'b01, 32'h21);
        cyc();
        m_req = 2'b01; s_rdata = 32'h22; exp_r(2'b01, 32'h22);
        exp_g(2'b01, 1'b0, 4'h0, 32'h40, 32'h0);
        #1;
        chk("pushpop_sreq", s_req, 1);
        cyc();
        s_data_ok = 1'b0;
        exp_g(2'b01, 1'b0, 4'h0, 32'h40, 32'h0);
        #1;
        chk("cnt3_sreq", s_req, 1);
        cyc();
        chk("cnt4_sreq", s_req, 0);
        m_req = '0; s_data_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_rdata = 32'h23 + k;
            exp_r(2'b01, 32'h23 + k);
            cyc();
        end
        s_data_ok = 1'b0;
        #1;
        chk("drain2_busy", busy, 0);

        // Out-of-channel-order issue, in-order routing
        set_ch(1, 1'b0, 4'h0, 32'h100, 32'h0);
        m_req = 2'b10;
        exp_g(2'b10, 1'b0, 4'h0, 32'h100, 32'h0);
        cyc();
        set_ch(0, 1'b0, 4'h0, 32'h200, 32'h0);
        m_req = 2'b01;
        exp_g(2'b01, 1'b0, 4'h0, 32'h200, 32'h0);
        cyc();
        m_req = '0; s_data_ok = 1'b1; s_rdata = 32'hA; exp_r(2'b10, 32'hA);
        cyc();
        s_rdata = 32'hB; exp_r(2'b01, 32'hB);
        cyc();

        // Stray response, sticky error, reset mid-stream
        #1;
        chk("stray_dok", m_data_ok, 0);
        chk("stray_err_pre", err_resp, 0);
        cyc();
        s_data_ok = 1'b0;
        #1;
        chk("stray_err", err_resp, 1);
        cyc(); cyc();
        chk("err_sticky", err_resp, 1);
        set_ch(0, 1'b0, 4'h0, 32'h300, 32'h0);
        m_req = 2'b01;
        exp_g(2'b01, 1'b0, 4'h0, 32'h300, 32'h0);
        exp_g(2'b01, 1'b0, 4'h0, 32'h300, 32'h0);
        cyc(); cyc();
        m_req = '0; s_addr_ok = 1'b0;
        #1;
        chk("mid_busy", busy, 1);
        rst_b = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err_resp, 0);
        chk("mrst_aok", m_addr_ok, 0);
        chk("mrst_dok", m_data_ok, 0);
        chk("mrst_sreq", s_req, 0);
        cyc();
        rst_b = 1'b1;
        s_addr_ok = 1'b1;
        set_ch(1, 1'b0, 4'h0, 32'h400, 32'h0);
        m_req = 2'b10;
        exp_g(2'b10, 1'b0, 4'h0, 32'h400, 32'h0);
        cyc();
        m_req = '0; s_data_ok = 1'b1; s_rdata = 32'h55; exp_r(2'b10, 32'h55);
        cyc();
        s_data_ok = 1'b0;
        #1;
        chk("post_busy", busy, 0);
        chk("post_err", err_resp, 0);
        cyc();
        chk("gq_empty", gq.size(), 0);
        chk("rq_empty", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
